// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates ALU vs long-latency writeback and
// tracks outstanding long-latency destinations to stall decode on RAW/WAW hazards.
module regfile_wb_scheduler #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 3
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic                                   issue_valid_i,
    input  logic [2:0]                             issue_type_i,
    input  logic [4:0]                             issue_rs1_i,
    input  logic [4:0]                             issue_rs2_i,
    input  logic [4:0]                             issue_rd_i,
    input  logic                                   issue_long_i,
    output logic                                   stall_o,
    input  logic                                   alu_wb_valid_i,
    input  logic [4:0]                             alu_wb_rd_i,
    input  logic [31:0]                            alu_wb_data_i,
    input  logic                                   lu_wb_valid_i,
    output logic                                   lu_wb_ready_o,
    input  logic [4:0]                             lu_wb_rd_i,
    input  logic [31:0]                            lu_wb_data_i,
    output logic                                   rf_we_o,
    output logic [4:0]                             rf_waddr_o,
    output logic [31:0]                            rf_wdata_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    // Instruction type encodings, matching the decode stage's define.v
    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_S = 3'd2;
    localparam logic [2:0] TYPE_B = 3'd3;
    localparam logic [2:0] TYPE_U = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;

    logic [31:0]      pending_q, pending_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             err_q, err_d;

    logic src1_vld, src2_vld, rd_wr;
    logic hazard, capacity, force_lu, stall_raw;
    logic accept, alu_go, lu_go, sb_set, cnt_dec;

    // Operand usage per instruction format
    always_comb begin
        src1_vld = 1'b0;
        src2_vld = 1'b0;
        rd_wr    = 1'b0;
        case (issue_type_i)
            TYPE_R:         begin src1_vld = 1'b1; src2_vld = 1'b1; rd_wr = 1'b1; end
            TYPE_I:         begin src1_vld = 1'b1; rd_wr = 1'b1; end
            TYPE_S, TYPE_B: begin src1_vld = 1'b1; src2_vld = 1'b1; end
            TYPE_U, TYPE_J: rd_wr = 1'b1;
            default:        ;
        endcase
        rd_wr = rd_wr & (issue_rd_i != 5'd0);
    end

    assign force_lu  = lu_wb_valid_i & (starve_q == STV_W'(STARVE_LIMIT));
    assign hazard    = (src1_vld & pending_q[issue_rs1_i])
                     | (src2_vld & pending_q[issue_rs2_i])
                     | (rd_wr    & pending_q[issue_rd_i]);
    assign capacity  = issue_long_i & rd_wr & (outstanding_q == OUT_W'(MAX_OUTSTANDING));
    assign stall_raw = issue_valid_i & (hazard | capacity | force_lu);
    assign accept    = rst_n_i & issue_valid_i & ~stall_raw;
    assign alu_go    = alu_wb_valid_i & ~issue_long_i & accept;
    assign lu_go     = rst_n_i & lu_wb_valid_i & ~alu_go;
    assign sb_set    = accept & issue_long_i & rd_wr;
    assign cnt_dec   = lu_go & (outstanding_q != '0);

    assign stall_o       = ~rst_n_i | stall_raw;
    assign lu_wb_ready_o = lu_go;
    assign outstanding_o = outstanding_q;
    assign err_o         = err_q;

    // Write port carries whichever source won arbitration
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = 32'd0;
        if (alu_go) begin
            rf_we_o    = (alu_wb_rd_i != 5'd0);
            rf_waddr_o = alu_wb_rd_i;
            rf_wdata_o = alu_wb_data_i;
        end else if (lu_go) begin
            rf_we_o    = (lu_wb_rd_i != 5'd0);
            rf_waddr_o = lu_wb_rd_i;
            rf_wdata_o = lu_wb_data_i;
        end
    end

    always_comb begin
        pending_d     = pending_q;
        outstanding_d = outstanding_q;
        starve_d      = starve_q;
        err_d         = err_q;

        if (lu_go) begin
            pending_d[lu_wb_rd_i] = 1'b0;
            if (!pending_q[lu_wb_rd_i]) err_d = 1'b1;
        end
        if (sb_set) pending_d[issue_rd_i] = 1'b1;
        pending_d[0] = 1'b0;

        case ({sb_set, cnt_dec})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: ;
        endcase

        // Saturating count of consecutive lost arbitrations
        if (lu_wb_valid_i && alu_go && (starve_q != STV_W'(STARVE_LIMIT)))
            starve_d = starve_q + STV_W'(1);
        if (lu_go || !lu_wb_valid_i)
            starve_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            starve_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            starve_q      <= starve_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed, table-driven bench for regfile_wb_scheduler (MAX_OUTSTANDING=4, STARVE_LIMIT=3).
module tb_regfile_wb_scheduler;

    localparam logic [2:0] TR = 3'd0, TI = 3'd1, TS = 3'd2, TU = 3'd4;

    logic        clk, rst_n;
    logic        iv, lng, av, lv;
    logic [2:0]  typ;
    logic [4:0]  rs1, rs2, rd, ard, lrd;
    logic [31:0] adat, ldat;
    logic        stall, rdy, we, err;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [2:0]  outst;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_scheduler #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .issue_valid_i(iv), .issue_type_i(typ), .issue_rs1_i(rs1), .issue_rs2_i(rs2),
        .issue_rd_i(rd), .issue_long_i(lng), .stall_o(stall),
        .alu_wb_valid_i(av), .alu_wb_rd_i(ard), .alu_wb_data_i(adat),
        .lu_wb_valid_i(lv), .lu_wb_ready_o(rdy), .lu_wb_rd_i(lrd), .lu_wb_data_i(ldat),
        .rf_we_o(we), .rf_waddr_o(wa), .rf_wdata_o(wd),
        .outstanding_o(outst), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic iv; logic [2:0] typ; logic [4:0] rs1, rs2, rd; logic lng;
        logic av; logic [4:0] ard; logic [31:0] adat;
        logic lv; logic [4:0] lrd; logic [31:0] ldat;
        logic e_stall, e_rdy, e_we; logic [4:0] e_wa; logic [31:0] e_wd;
        logic [2:0] e_out; logic e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic i_v, logic [2:0] t, logic [4:0] s1, logic [4:0] s2,
                                logic [4:0] d, logic l, logic a_v, logic [4:0] a_rd,
                                logic [31:0] a_d, logic l_v, logic [4:0] l_rd, logic [31:0] l_d,
                                logic es, logic er, logic ew, logic [4:0] ewa,
                                logic [31:0] ewd, logic [2:0] eo, logic ee);
        vec_t v;
        v.iv = i_v; v.typ = t; v.rs1 = s1; v.rs2 = s2; v.rd = d; v.lng = l;
        v.av = a_v; v.ard = a_rd; v.adat = a_d; v.lv = l_v; v.lrd = l_rd; v.ldat = l_d;
        v.e_stall = es; v.e_rdy = er; v.e_we = ew; v.e_wa = ewa; v.e_wd = ewd;
        v.e_out = eo; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        iv = v.iv; typ = v.typ; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; lng = v.lng;
        av = v.av; ard = v.ard; adat = v.adat; lv = v.lv; lrd = v.lrd; ldat = v.ldat;
    endtask

    task automatic check_all(int idx, logic es, logic er, logic ew, logic [4:0] ewa,
                             logic [31:0] ewd, logic [2:0] eo, logic ee);
        chk("stall_o", idx, 32'(stall), 32'(es));
        chk("lu_wb_ready_o", idx, 32'(rdy), 32'(er));
        chk("rf_we_o", idx, 32'(we), 32'(ew));
        chk("rf_waddr_o", idx, 32'(wa), 32'(ewa));
        chk("rf_wdata_o", idx, wd, ewd);
        chk("outstanding_o", idx, 32'(outst), 32'(eo));
        chk("err_o", idx, 32'(err), 32'(ee));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Ordinary ALU op, then RAW on a long result
        vecs.push_back(mk(1,TR, 1,2, 3,0, 1, 3,32'h11, 0, 0,0,  0,0,1, 3,32'h11, 0,0));
        vecs.push_back(mk(1,TI, 0,0, 5,1, 0, 0,0,      0, 0,0,  0,0,0, 0,0,      0,0));
        vecs.push_back(mk(1,TR, 1,5, 4,0, 1, 4,32'h22, 0, 0,0,  1,0,0, 0,0,      1,0));
        vecs.push_back(mk(1,TR, 1,5, 4,0, 1, 4,32'h22, 1, 5,32'h55, 1,1,1, 5,32'h55, 1,0));
        vecs.push_back(mk(1,TR, 1,5, 4,0, 1, 4,32'h22, 0, 0,0,  0,0,1, 4,32'h22, 0,0));
        // Fill to capacity, fifth long issue waits for one completion
        vecs.push_back(mk(1,TI, 0,0, 6,1, 0, 0,0, 0, 0,0, 0,0,0, 0,0, 0,0));
        vecs.push_back(mk(1,TI, 0,0, 7,1, 0, 0,0, 0, 0,0, 0,0,0, 0,0, 1,0));
        vecs.push_back(mk(1,TI, 0,0, 8,1, 0, 0,0, 0, 0,0, 0,0,0, 0,0, 2,0));
        vecs.push_back(mk(1,TI, 0,0, 9,1, 0, 0,0, 0, 0,0, 0,0,0, 0,0, 3,0));
        vecs.push_back(mk(1,TI, 0,0,10,1, 0, 0,0, 0, 0,0, 1,0,0, 0,0, 4,0));
        vecs.push_back(mk(1,TI, 0,0,10,1, 0, 0,0, 1, 6,32'h66, 1,1,1, 6,32'h66, 4,0));
        vecs.push_back(mk(1,TI, 0,0,10,1, 0, 0,0, 0, 0,0, 0,0,0, 0,0, 3,0));
        vecs.push_back(mk(0,TI, 0,0, 0,0, 0, 0,0, 1, 7,32'h77, 0,1,1, 7,32'h77, 4,0));
        vecs.push_back(mk(0,TI, 0,0, 0,0, 0, 0,0, 1, 8,32'h88, 0,1,1, 8,32'h88, 3,0));
        vecs.push_back(mk(0,TI, 0,0, 0,0, 0, 0,0, 1, 9,32'h99, 0,1,1, 9,32'h99, 2,0));
        vecs.push_back(mk(0,TI, 0,0, 0,0, 0, 0,0, 1,10,32'hAA, 0,1,1,10,32'hAA, 1,0));
        vecs.push_back(mk(0,TI, 0,0, 0,0, 0, 0,0, 0, 0,0,      0,0,0, 0,0,      0,0));
        // Starvation: ALU wins three cycles, fourth is forced to the long unit
        vecs.push_back(mk(1,TI, 0,0,13,1, 0, 0,0,      0, 0,0,       0,0,0, 0,0,       0,0));
        vecs.push_back(mk(1,TR, 1,2, 3,0, 1, 3,32'hA0, 1,13,32'hD0, 0,0,1, 3,32'hA0,  1,0));
        vecs.push_back(mk(1,TR, 1,2, 3,0, 1, 3,32'hA1, 1,13,32'hD0, 0,0,1, 3,32'hA1,  1,0));
        vecs.push_back(mk(1,TR, 1,2, 3,0, 1, 3,32'hA2, 1,13,32'hD0, 0,0,1, 3,32'hA2,  1,0));
        vecs.push_back(mk(1,TR, 1,2, 3,0, 1, 3,32'hA3, 1,13,32'hD0, 1,1,1,13,32'hD0,  1,0));
        vecs.push_back(mk(1,TR, 1,2, 3,0, 1, 3,32'hA3, 0, 0,0,      0,0,1, 3,32'hA3,  0,0));
        // Spurious long result, then S-type rd field ignored by the scoreboard
        vecs.push_back(mk(0,TI, 0,0, 0,0, 0, 0,0, 1,12,32'hC0, 0,1,1,12,32'hC0, 0,0));
        vecs.push_back(mk(1,TI, 0,0,12,1, 0, 0,0, 0, 0,0,      0,0,0, 0,0,      0,1));
        vecs.push_back(mk(1,TS, 1,2,12,0, 0, 0,0, 0, 0,0,      0,0,0, 0,0,      1,1));
        vecs.push_back(mk(0,TI, 0,0, 0,0, 0, 0,0, 1,12,32'hC1, 0,1,1,12,32'hC1, 1,1));
        vecs.push_back(mk(0,TI, 0,0, 0,0, 0, 0,0, 0, 0,0,      0,0,0, 0,0,      0,1));
        // Write to x0 is suppressed
        vecs.push_back(mk(1,TU, 0,0, 0,0, 1, 0,32'h99, 0, 0,0, 0,0,0, 0,32'h99, 0,1));

        // Outputs held at reset values while rst_n is low
        rst_n = 1'b0;
        drive(mk(1,TR, 1,2, 3,0, 1, 3,32'h11, 1, 4,32'h44, 0,0,0,0,0,0,0));
        #2;
        check_all(-1, 1, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #3;
            check_all(i, vecs[i].e_stall, vecs[i].e_rdy, vecs[i].e_we, vecs[i].e_wa,
                      vecs[i].e_wd, vecs[i].e_out, vecs[i].e_err);
            step();
        end

        // Reset asserted mid-cycle with two results outstanding
        drive(mk(1,TI, 0,0,20,1, 0, 0,0, 0, 0,0, 0,0,0,0,0,0,0));
        step();
        drive(mk(1,TI, 0,0,21,1, 0, 0,0, 0, 0,0, 0,0,0,0,0,0,0));
        step();
        drive(mk(1,TR, 1,2, 3,0, 1, 3,32'h33, 1,20,32'hEE, 0,0,0,0,0,0,0));
        #2;
        chk("outstanding_o pre-reset", 100, 32'(outst), 32'd2);
        chk("rf_we_o pre-reset", 100, 32'(we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all(101, 1, 0, 0, 0, 0, 0, 0);
        step();
        check_all(102, 1, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(mk(1,TR,20,21,22,0, 1,22,32'h44, 0, 0,0, 0,0,0,0,0,0,0));
        #2;
        check_all(103, 0, 0, 1, 22, 32'h44, 0, 0);
        step();
        drive(mk(0,TI, 0,0, 0,0, 0, 0,0, 1,20,32'hEE, 0,0,0,0,0,0,0));
        #2;
        check_all(104, 0, 1, 1, 20, 32'hEE, 0, 0);
        step();
        drive(mk(0,TI, 0,0, 0,0, 0, 0,0, 0, 0,0, 0,0,0,0,0,0,0));
        #2;
        check_all(105, 0, 0, 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Schedules the single register-file write port between the single-cycle ALU writeback path and a long-latency unit (load/mul/div) result path.
- Keeps a 32-entry pending-write scoreboard so decode stalls on RAW/WAW hazards against outstanding long-latency results.
- Sits between decode/issue and access_register_file, producing stall_o and the register-file write controls.

Parameters:
- MAX_OUTSTANDING, 4: maximum in-flight long-latency instructions; must be 1..31.
- STARVE_LIMIT, 3: consecutive cycles the long-unit write may lose arbitration before it is forced through; must be ≥1.

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_n_i  input  1  asynchronous active-low reset
- issue_valid_i  input  1  decode presents an instruction this cycle
- issue_type_i  input  3  instruction type, `TYPER/`TYPEI/`TYPES/`TYPEB/`TYPEU/`TYPEJ codes from define.v
- issue_rs1_i  input  5  source register 1
- issue_rs2_i  input  5  source register 2
- issue_rd_i  input  5  destination register
- issue_long_i  input  1  instruction completes in the long-latency unit
- stall_o  output  1  hold fetch/decode; instruction not accepted
- alu_wb_valid_i  input  1  ALU result ready this cycle (same-cycle as issue)
- alu_wb_rd_i  input  5  ALU destination
- alu_wb_data_i  input  32  ALU result
- lu_wb_valid_i  input  1  long unit has a result
- lu_wb_ready_o  output  1  long-unit result granted the write port this cycle
- lu_wb_rd_i  input  5  long-unit destination
- lu_wb_data_i  input  32  long-unit result
- rf_we_o  output  1  register-file write enable
- rf_waddr_o  output  5  write address
- rf_wdata_o  output  32  write data
- outstanding_o  output  clog2(MAX_OUTSTANDING+1)  in-flight long-latency count
- err_o  output  1  sticky protocol error

Behaviour:
- State:
  - pending[31:1] scoreboard; bit 0 is hard-wired 0.
  - Outstanding counter.
  - Starve counter, width clog2(STARVE_LIMIT+1).
  - err flag.
  - Reset (async, rst_n_i low) clears all of these to 0.
- Outputs while in reset: stall_o=1, rf_we_o=0, lu_wb_ready_o=0, rf_waddr_o=0, rf_wdata_o=0, outstanding_o=0, err_o=0.
- Outputs are combinational from state plus inputs, except outstanding_o and err_o, which are registered.
- Source and destination validity:
  - src1 valid for R/I/S/B; src2 valid for R/S/B.
  - rd writes for R/I/U/J, and only when rd≠0.
- Force: force = lu_wb_valid_i & (starve == STARVE_LIMIT).
- stall_o = issue_valid_i & (hazard | capacity | force), where:
  - hazard = (src1 valid & pending[rs1]) | (src2 valid & pending[rs2]) | (rd writes & pending[rd]).
  - capacity = issue_long_i & rd writes & (outstanding == MAX_OUTSTANDING).
  - A pending bit cleared in the same cycle does NOT release the stall; no bypass. The issue is accepted the next cycle.
- Accept: accept = issue_valid_i & !stall_o.
- Write-port arbitration:
  - alu_go = alu_wb_valid_i & !issue_long_i & accept.
  - lu_wb_ready_o = lu_wb_valid_i & !alu_go.
  - The ALU wins by default; force blocks the issue, so the long unit wins.
  - rf_* carries the winner. rf_we_o=0 if the winner's rd=0.
- Starve counter:
  - Increments when lu_wb_valid_i & alu_go.
  - Clears on lu_wb_ready_o or !lu_wb_valid_i.
  - Never exceeds STARVE_LIMIT.
- Scoreboard and counter updates:
  - On accept & issue_long_i & rd writes: set pending[rd] and increment outstanding.
  - On lu_wb_ready_o: clear pending[lu_wb_rd_i] and decrement outstanding.
  - Both in one cycle: the set and the clear apply independently, so the net count is unchanged. The same register cannot collide because of the WAW stall.
- Errors:
  - err sets on lu_wb_ready_o with pending[lu_wb_rd_i]=0. This includes rd=0 and the counter at 0; the counter does not underflow.
  - err clears only by reset.
- Reset asserted mid-operation: all pending bits are discarded. An in-flight long result is written only if it is presented after reset and granted, and it then flags err.

Test Plan:
1. Reset release, then a `TYPER issue with rs1=1, rs2=2, rd=3, ALU valid, data 0x11 → stall_o=0, rf_we_o=1, waddr=3, wdata=0x11, outstanding_o=0.
2. Long `TYPEI issue with rd=5, then a `TYPER issue using rs2=5 → stall_o=1 every cycle until lu_wb_valid with rd=5 is granted, and the cycle after the grant. On that following cycle stall_o=0 and outstanding_o returns 0.
3. Issue 4 long-latency instructions to rd=6..9 with no results returned → fifth long issue stalls with outstanding_o=4. One lu grant → outstanding_o=3 and the fifth issue is accepted.
4. lu_wb_valid held with ALU writes every cycle and STARVE_LIMIT=3 → ALU wins 3 cycles. Cycle 4: stall_o=1, lu_wb_ready_o=1, rf_waddr_o=lu rd.
5. lu result to rd=12 while pending[12]=0 → err_o=1 next cycle, outstanding stays 0. A `TYPES issue with rd field 12 is never stalled by pending[12].
6. Assert rst_n_i low between clock edges with outstanding=2 → outputs go to reset values immediately and pending is empty after release.
